// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM receive chain: FSM state codes, the
// 802.11a default lengths and the settings-register offsets.
package ofdm_pkg;

    // CP-strip FSM state codes
    localparam logic [1:0] ST_CP   = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAD  = 2'd2;

    // Power-up lengths (802.11a: 16-sample CP, 64-point FFT)
    localparam int DEF_CP_LEN  = 16;
    localparam int DEF_FFT_LEN = 64;

    // Settings-bus offset of the packed {cp_len, fft_len} register
    localparam int SR_CP_STRIP_LEN = 0;

endpackage

// File: rtl/ofdm_len_regs.sv
// Settings decode and length registers for the CP stripper.
// Staged lengths follow settings writes immediately. Active lengths copy the
// staged ones on load_i (symbol start) or clear_i. While load_i is high the
// outputs show the staged values, so a symbol starting this very cycle
// already uses the new lengths.
module ofdm_len_regs
    import ofdm_pkg::*;
#(
    parameter int BASE         = 0,
    parameter int MAX_LEN_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    set_stb_i,
    input  logic [7:0]              set_addr_i,
    input  logic [31:0]             set_data_i,
    input  logic                    load_i,
    output logic [MAX_LEN_LOG2-1:0] cp_len_o,
    output logic [MAX_LEN_LOG2-1:0] fft_len_o
);

    localparam int              W        = MAX_LEN_LOG2;
    localparam logic [7:0]      LEN_ADDR = 8'(BASE + SR_CP_STRIP_LEN);
    localparam logic [15:0]     MAX_V    = 16'((1 << W) - 1);
    localparam logic [W-1:0]    DEF_CP   = W'(DEF_CP_LEN);
    localparam logic [W-1:0]    DEF_FFT  = W'(DEF_FFT_LEN);
    localparam logic [W-1:0]    MIN_FFT  = W'(2);

    // Saturate a 16-bit length field to the counter range
    function automatic logic [W-1:0] sat_len(input logic [15:0] v);
        if (v > MAX_V) begin
            return MAX_V[W-1:0];
        end else begin
            return v[W-1:0];
        end
    endfunction

    logic [W-1:0] cp_stage_q, fft_stage_q;
    logic [W-1:0] cp_act_q, fft_act_q;
    logic         wr_s;
    logic [W-1:0] cp_new_s, fft_new_s;

    assign wr_s = set_stb_i && (set_addr_i == LEN_ADDR);

    // Decode the written lengths; an FFT shorter than 2 cannot frame a symbol
    always_comb begin
        cp_new_s  = sat_len(set_data_i[31:16]);
        fft_new_s = sat_len(set_data_i[15:0]);
        if (fft_new_s < MIN_FFT) begin
            fft_new_s = MIN_FFT;
        end else begin
            fft_new_s = fft_new_s;
        end
    end

    // Staged and active length registers; clear keeps the staged values
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cp_stage_q  <= DEF_CP;
            fft_stage_q <= DEF_FFT;
            cp_act_q    <= DEF_CP;
            fft_act_q   <= DEF_FFT;
        end else begin
            if (wr_s) begin
                cp_stage_q  <= cp_new_s;
                fft_stage_q <= fft_new_s;
            end
            if (clear_i || load_i) begin
                cp_act_q  <= cp_stage_q;
                fft_act_q <= fft_stage_q;
            end
        end
    end

    assign cp_len_o  = load_i ? cp_stage_q  : cp_act_q;
    assign fft_len_o = load_i ? fft_stage_q : fft_act_q;

endmodule

// File: rtl/ofdm_cp_strip.sv
// Cyclic-prefix stripper: drops CP_LEN samples at the start of each symbol,
// forwards FFT_LEN data samples with o_tlast on the last one, and zero-pads a
// symbol cut short by the end of the frame.
// Optional feature macro: OFDM_CP_STRIP_EOB_EN adds o_teob, flagging the last
// symbol of each frame.
module ofdm_cp_strip
    import ofdm_pkg::*;
#(
    parameter int BASE         = 0,
    parameter int WIDTH        = 32,
    parameter int MAX_LEN_LOG2 = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
`ifdef OFDM_CP_STRIP_EOB_EN
    output logic             o_teob,
`endif
    input  logic             o_tready
);

    localparam int           W    = MAX_LEN_LOG2;
    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONE  = W'(1);

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] tdata_q, tdata_d;
    logic             tlast_q, tlast_d;
    logic             tvalid_q, tvalid_d;
    logic             teob_q, teob_d;
    logic [W-1:0]     cp_len_s, fft_len_s;
    logic             ld_s, load_len_s, in_data_s, fft_last_s, cp_last_s;

    assign load_len_s = (state_q == ST_CP) && (cnt_q == ZERO);

    ofdm_len_regs #(
        .BASE         (BASE),
        .MAX_LEN_LOG2 (MAX_LEN_LOG2)
    ) u_len_regs (
        .clk        (clk),
        .reset_i    (reset),
        .clear_i    (clear),
        .set_stb_i  (set_stb),
        .set_addr_i (set_addr),
        .set_data_i (set_data),
        .load_i     (load_len_s),
        .cp_len_o   (cp_len_s),
        .fft_len_o  (fft_len_s)
    );

    // With a zero-length CP the symbol-start cycle already carries data
    assign in_data_s  = (state_q == ST_DATA) || (load_len_s && (cp_len_s == ZERO));
    assign ld_s       = ~tvalid_q | o_tready;
    assign fft_last_s = (cnt_q == (fft_len_s - ONE));
    assign cp_last_s  = (cnt_q == (cp_len_s - ONE));

    // Input ready: always in CP, only when the output register can load in DATA
    always_comb begin
        i_tready = 1'b0;
        if (in_data_s) begin
            i_tready = ld_s;
        end else if (state_q == ST_CP) begin
            i_tready = 1'b1;
        end else begin
            i_tready = 1'b0;
        end
    end

    // Next-state, counter and output-register logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        teob_d   = teob_q;
        tvalid_d = ld_s ? 1'b0 : tvalid_q;
        if (in_data_s) begin
            if (i_tvalid && ld_s) begin
                tdata_d  = i_tdata;
                tlast_d  = fft_last_s;
                teob_d   = fft_last_s && i_tlast;
                tvalid_d = 1'b1;
                if (fft_last_s) begin
                    state_d = ST_CP;
                    cnt_d   = ZERO;
                end else if (i_tlast) begin
                    state_d = ST_PAD;
                    cnt_d   = cnt_q + ONE;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = cnt_q + ONE;
                end
            end else begin
                state_d = state_q;
            end
        end else begin
            case (state_q)
                ST_CP: begin
                    if (i_tvalid) begin
                        if (i_tlast) begin
                            state_d = ST_CP;
                            cnt_d   = ZERO;
                        end else if (cp_last_s) begin
                            state_d = ST_DATA;
                            cnt_d   = ZERO;
                        end else begin
                            cnt_d   = cnt_q + ONE;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_PAD: begin
                    if (ld_s) begin
                        tdata_d  = {WIDTH{1'b0}};
                        tlast_d  = fft_last_s;
                        teob_d   = fft_last_s;
                        tvalid_d = 1'b1;
                        if (fft_last_s) begin
                            state_d = ST_CP;
                            cnt_d   = ZERO;
                        end else begin
                            cnt_d   = cnt_q + ONE;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_CP;
                    cnt_d   = ZERO;
                end
            endcase
        end
    end

    // State and output registers; reset and clear both drop any partial symbol
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q  <= ST_CP;
            cnt_q    <= ZERO;
            tdata_q  <= {WIDTH{1'b0}};
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            teob_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            teob_q   <= teob_d;
        end
    end

    assign o_tdata  = tdata_q;
    assign o_tlast  = tlast_q;
    assign o_tvalid = tvalid_q;
`ifdef OFDM_CP_STRIP_EOB_EN
    assign o_teob   = teob_q;
`else
    logic unused_teob_s;
    assign unused_teob_s = teob_q;
`endif

endmodule

// File: tb/tb_ofdm_cp_strip.sv
// Self-checking bench for ofdm_cp_strip. A frame-level reference model
// predicts every output beat; a negedge monitor captures handshaken beats and
// checks output stability during back-pressure.
module tb_ofdm_cp_strip;

    logic        clk = 1'b0;
    logic        reset, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] i_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_tvalid, o_tready;
    logic        eob_s;
`ifdef OFDM_CP_STRIP_EOB_EN
    logic        o_teob;
    assign eob_s = o_teob;
`else
    assign eob_s = 1'b0;
`endif

    ofdm_cp_strip dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
`ifdef OFDM_CP_STRIP_EOB_EN
        .o_teob   (o_teob),
`endif
        .o_tready (o_tready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rnd_rdy  = 1'b0;
    int in_cyc [0:1023];

    logic [31:0] exp_d[$], got_d[$];
    logic        exp_l[$], got_l[$], exp_e[$], got_e[$];
    int          got_cyc[$];

    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last, prev_eob;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: capture accepted beats, verify holding during stalls
    always @(negedge clk) begin
        if (!reset) begin
            if (stall_prev) begin
                chk("stall_data", 64'(o_tdata), 64'(prev_data));
                chk("stall_last", 64'(o_tlast), 64'(prev_last));
`ifdef OFDM_CP_STRIP_EOB_EN
                chk("stall_eob", 64'(eob_s), 64'(prev_eob));
`endif
            end
            if (o_tvalid && o_tready) begin
                got_d.push_back(o_tdata);
                got_l.push_back(o_tlast);
                got_e.push_back(eob_s);
                got_cyc.push_back(cyc + 1);
            end
            stall_prev = o_tvalid && !o_tready;
            prev_data  = o_tdata;
            prev_last  = o_tlast;
            prev_eob   = eob_s;
        end
    end

    // One clock step; inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        set_stb = 1'b0;
        clear   = 1'b0;
        o_tready = rnd_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
    endtask

    // Reference model: symbol-by-symbol view of a frame of n ramp samples.
    // Symbols numbered >= nsw use the second pair of lengths.
    task automatic add_exp(input int base, input int n, input int cp, input int fft,
                           input int nsw, input int cp2, input int fft2);
        int idx = 0;
        int sym = 0;
        while (idx < n) begin
            int c = (sym < nsw) ? cp : cp2;
            int f = (sym < nsw) ? fft : fft2;
            int k;
            if (n - idx <= c) break;
            idx += c;
            k = (n - idx < f) ? (n - idx) : f;
            for (int j = 0; j < f; j++) begin
                exp_d.push_back((j < k) ? 32'(base + idx + j) : 32'd0);
                exp_l.push_back(j == f - 1);
                exp_e.push_back((j == f - 1) && (idx + k == n));
            end
            idx += k;
            sym++;
        end
    endtask

    // Send a frame; ctl_kind 1 = settings write, 2 = clear, at beat ctl_at
    task automatic send_frame(input int base, input int n, input int ctl_at,
                              input int ctl_kind, input logic [31:0] ctl_data);
        for (int k = 0; k < n; k++) begin
            bit acc = 1'b0;
            int waited = 0;
            i_tdata  = 32'(base + k);
            i_tlast  = (k == n - 1);
            i_tvalid = 1'b1;
            if (k == ctl_at && ctl_kind == 1) begin
                set_stb  = 1'b1;
                set_data = ctl_data;
            end else if (k == ctl_at && ctl_kind == 2) begin
                clear = 1'b1;
            end
            while (!acc) begin
                @(negedge clk);
                if (i_tready) begin
                    acc = 1'b1;
                    if (k < 1024) in_cyc[k] = cyc + 1;
                end
                tick();
                waited++;
                if (!acc && waited > 2000) begin
                    chk("in_accept_bound", 64'(waited), 64'(2000));
                    i_tvalid = 1'b0;
                    i_tlast  = 1'b0;
                    return;
                end
            end
            if (ctl_kind == 2 && k == ctl_at) begin
                i_tvalid = 1'b0;
                i_tlast  = 1'b0;
                return;
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic drain_compare(input string tag);
        int budget = 0;
        int m;
        while (got_d.size() < exp_d.size() && budget < 5000) begin
            tick();
            budget++;
        end
        repeat (8) tick();
        chk({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
        m = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, "_data"}, 64'(got_d[i]), 64'(exp_d[i]));
            chk({tag, "_last"}, 64'(got_l[i]), 64'(exp_l[i]));
`ifdef OFDM_CP_STRIP_EOB_EN
            chk({tag, "_eob"}, 64'(got_e[i]), 64'(exp_e[i]));
`endif
        end
        got_d.delete(); got_l.delete(); got_e.delete();
        exp_d.delete(); exp_l.delete(); exp_e.delete();
    endtask

    task automatic set_len(input int cp, input int fft);
        set_stb  = 1'b1;
        set_addr = 8'd0;
        set_data = {16'(cp), 16'(fft)};
        tick();
        tick();
    endtask

    initial begin
        int b;
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        i_tdata = 32'd0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_tdata", 64'(o_tdata), 64'd0);
        chk("rst_tlast", 64'(o_tlast), 64'd0);
        chk("rst_tready", 64'(i_tready), 64'd1);
        tick();

        // Two full default symbols, ramp 0..159, latency and throughput
        got_cyc.delete();
        add_exp(0, 160, 16, 64, 1000, 0, 0);
        send_frame(0, 160, -1, 0, 32'd0);
        drain_compare("two_sym");
        chk("latency_sym0", 64'(got_cyc[0]), 64'(in_cyc[16] + 1));
        chk("latency_sym1", 64'(got_cyc[64]), 64'(in_cyc[96] + 1));
        chk("throughput", 64'(got_cyc[63] - got_cyc[0]), 64'd63);

        // Frame ends at data offset 24 -> zero pad, i_tready low in PAD
        b = int'($urandom_range(1000, 100000));
        add_exp(b, 41, 16, 64, 1000, 0, 0);
        send_frame(b, 41, -1, 0, 32'd0);
        @(negedge clk);
        chk("pad_tready", 64'(i_tready), 64'd0);
        drain_compare("pad");

        // Frame ends inside the CP, then a fresh frame
        b = int'($urandom_range(1000, 100000));
        add_exp(b, 11, 16, 64, 1000, 0, 0);
        send_frame(b, 11, -1, 0, 32'd0);
        b = int'($urandom_range(1000, 100000));
        add_exp(b, 80, 16, 64, 1000, 0, 0);
        send_frame(b, 80, -1, 0, 32'd0);
        drain_compare("cp_end");

        // Length change mid-symbol takes effect at the next symbol
        b = int'($urandom_range(1000, 100000));
        add_exp(b, 104, 16, 64, 1, 0, 8);
        send_frame(b, 104, 30, 1, {16'd0, 16'd8});
        drain_compare("len_change");

        // Random back-pressure over five default symbols
        set_len(16, 64);
        rnd_rdy = 1'b1;
        b = int'($urandom_range(1000, 100000));
        add_exp(b, 400, 16, 64, 1000, 0, 0);
        send_frame(b, 400, -1, 0, 32'd0);
        drain_compare("backpressure");
        rnd_rdy = 1'b0;
        tick();

        // Clear during DATA at cnt 20, lengths retained afterwards
        set_len(4, 32);
        b = int'($urandom_range(1000, 100000));
        for (int j = 4; j < 24; j++) begin
            exp_d.push_back(32'(b + j));
            exp_l.push_back(1'b0);
            exp_e.push_back(1'b0);
        end
        send_frame(b, 200, 24, 2, 32'd0);
        @(negedge clk);
        chk("clear_tvalid", 64'(o_tvalid), 64'd0);
        chk("clear_tready", 64'(i_tready), 64'd1);
        drain_compare("clear_partial");
        b = int'($urandom_range(1000, 100000));
        add_exp(b, 72, 4, 32, 1000, 0, 0);
        send_frame(b, 72, -1, 0, 32'd0);
        drain_compare("after_clear");

        // fft_len of 1 clamps to 2, no CP, odd frame length pads one beat
        set_len(0, 1);
        b = int'($urandom_range(1000, 100000));
        add_exp(b, 5, 0, 2, 1000, 0, 0);
        send_frame(b, 5, -1, 0, 32'd0);
        drain_compare("clamp");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
